uart_cfg_tuner: RTL and testbench
=================================

# uart_cfg_tuner

Sequential configuration store for the parametrised UART. It accepts a configuration request over a valid/ready handshake and converts the baud-rate code into a bit pulse width for any `CLK_FREQ` using an iterative divider; a direct-divisor mode bypasses the divider. The new setting is committed atomically only while the link reports idle. It sits between the host/control side and the UART TX/RX cores, which consume its registered outputs.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, system clock in Hz.
- `PW_W`, 19, pulse-width bits; holds the 300-baud value at 50 MHz.
- `NUM_W`, `$clog2(CLK_FREQ + 460_800 + 1)`, divider numerator width; derived, not overridden.

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, reset; **one clock; reset is asynchronous and active-low**.
- `cfg_valid`, in, 1, request valid.
- `cfg_ready`, out, 1, block can accept a request.
- `br`, in, 4, `baud_rate` code.
- `custom_en`, in, 1, use `custom_div` instead of `br`.
- `custom_div`, in, PW_W, direct pulse width.
- `sbl`, in, 2, `stop_bit_length`.
- `data_len`, in, 2, `data_length` code: 00=5, 01=6, 10=7, 11=8 bits.
- `parity_on`, `seniority_h`, `parity_set`, in, 1 each, same meaning as the existing tuner fields.
- `link_idle`, in, 1, TX and RX both idle.
- `cfg_o`, out, `tuner_output_bus_t`, committed configuration.
- `cfg_applied`, out, 1, one-cycle pulse when `cfg_o` changes.
- `cfg_err`, out, 1, one-cycle pulse when a request is rejected.
- `busy`, out, 1, high whenever the FSM is not in IDLE.

## Operation
FSM states:
- **IDLE**: `cfg_ready`=1. On `cfg_valid`, capture all inputs into a shadow register.
  - `custom_en`=1 with `custom_div`≠0: go to WAIT_IDLE.
  - `custom_en`=1 with `custom_div`=0: go to ERR.
  - `br`>12: go to ERR.
  - Otherwise: load the divider and go to CALC.
- **CALC**: restoring division, one quotient bit per cycle, exactly NUM_W cycles.
  - Quotient = floor((CLK_FREQ + baud/2) / baud), i.e. round to nearest.
  - Quotient 0 or ≥2^PW_W: go to ERR. Otherwise go to WAIT_IDLE.
- **WAIT_IDLE**: hold until `link_idle`=1, then go to APPLY. There is no timeout.
- **APPLY**: `cfg_o` ← shadow; `cfg_applied` pulses; go to IDLE.
- **ERR**: `cfg_err` pulses; `cfg_o` is unchanged; go to IDLE.

Rules:
- `cfg_ready`=0 outside IDLE. The requester holds `cfg_valid` and data until accepted; inputs outside the accept cycle are ignored.
- `cfg_o` is never partially updated. All fields change on the same edge.
- `sbl`=11 is reserved and mapped to ONE. This is not an error.
- Reset values: state IDLE; `cfg_ready`=1; `busy`, `cfg_applied`, `cfg_err` = 0.
- Reset value of `cfg_o`: pulse_width = round(CLK_FREQ/9600) (5208 at 50 MHz), sbl=ONE, data_len=8, parity_on=0, seniority_h=0, parity_set=0.
- Reset asserted mid-CALC or mid-WAIT_IDLE: the pending request is discarded and outputs return to reset values immediately (asynchronous).

## Timing
Request accepted at cycle T:
- Divider path with `link_idle` high: CALC spans T+1..T+NUM_W, WAIT_IDLE at T+NUM_W+1, APPLY at T+NUM_W+2. New `cfg_o` and `cfg_applied`=1 are visible in cycle T+NUM_W+3.
- Custom path: new `cfg_o` and `cfg_applied` visible at T+3.
- `br` error: `cfg_err`=1 in cycle T+2.
- Divider overflow error: `cfg_err`=1 in cycle T+NUM_W+2.
- `link_idle` low: every cycle it stays low adds one cycle to the latency.
- `cfg_ready` is high again in the same cycle `cfg_applied` or `cfg_err` is high. A back-to-back request may be accepted in that cycle.
- `cfg_ready` and `busy` are registered. The `cfg_applied` and `cfg_err` pulses are registered and exactly one cycle wide.

## Structure
- `uart_tuner_pkg` contains:
  - `baud_rate`, `stop_bit_length` and `data_length` enums.
  - Extended `tuner_output_bus_t`, parametrised by adding `data_len`; pulse_width is PW_W bits.
  - `baud_hz(baud_rate)` constant function (300…921600).
  - `default_cfg(CLK_FREQ)` function.
- Sub-module `uart_baud_div`: NUM_W-cycle restoring divider with `start`/`done`, holding the quotient and an overflow flag. The FSM in `uart_cfg_tuner` instantiates it once.

## Test plan
- Reset, then read `cfg_o` → pulse_width 5208, sbl=ONE, data_len=8, parity off; `cfg_ready`=1.
- `br`=R_115200, `link_idle`=1 → `cfg_applied` at T+NUM_W+3 (T+29 at 50 MHz, NUM_W=26); pulse_width 434. Also `br`=R_300 → 166667.
- `custom_en`=1, `custom_div`=100, `link_idle`=0 for 10 cycles → `cfg_o` unchanged while `link_idle`=0; applied at T+13 with pulse_width 100; `cfg_ready`=0 throughout.
- `br`=4'b1101, then `custom_div`=0 with `custom_en`=1 → `cfg_err` pulse at T+2 for each; `cfg_o` untouched; `cfg_applied` never asserts.
- `CLK_FREQ`=200_000_000, `br`=R_300 → quotient 666667 ≥ 2^19 → `cfg_err`; previous config kept.
- `rst_n` low for 1 cycle mid-CALC of an R_9600 request → immediate defaults, no `cfg_applied`; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/uart_tuner_pkg.sv
// uart_tuner_pkg
//   Shared types and helpers for the UART configuration tuner.
//   - baud_rate / stop_bit_length / data_length code enums
//   - tuner_output_bus_t : committed configuration seen by the TX/RX cores
//   - tuner_state_t      : configuration FSM states
//   - baud_hz()          : baud code -> baud rate in Hz
//   - map_sbl()          : stop-bit code -> enum (reserved 2'b11 folds to ONE)
//   - default_cfg()      : power-on configuration (9600 baud, 8N1)
package uart_tuner_pkg;

  // Width of the pulse_width field carried on the output bus. Instances of
  // uart_cfg_tuner must use the same PW_W.
  localparam int TUNER_PW_W = 19;
  // Wide enough for the fastest supported baud rate (921600).
  localparam int BAUD_W = 20;
  localparam logic [3:0] BR_MAX = 4'd12;

  typedef enum logic [3:0] {
    R_300    = 4'd0,
    R_600    = 4'd1,
    R_1200   = 4'd2,
    R_2400   = 4'd3,
    R_4800   = 4'd4,
    R_9600   = 4'd5,
    R_19200  = 4'd6,
    R_38400  = 4'd7,
    R_57600  = 4'd8,
    R_115200 = 4'd9,
    R_230400 = 4'd10,
    R_460800 = 4'd11,
    R_921600 = 4'd12
  } baud_rate;

  typedef enum logic [1:0] {
    STOP_ONE      = 2'b00,
    STOP_ONE_HALF = 2'b01,
    STOP_TWO      = 2'b10
  } stop_bit_length;

  typedef enum logic [1:0] {
    DATA_5 = 2'b00,
    DATA_6 = 2'b01,
    DATA_7 = 2'b10,
    DATA_8 = 2'b11
  } data_length;

  typedef struct packed {
    logic [TUNER_PW_W-1:0] pulse_width;
    stop_bit_length        sbl;
    data_length            data_len;
    logic                  parity_on;
    logic                  seniority_h;
    logic                  parity_set;
  } tuner_output_bus_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CALC      = 3'd1,
    S_WAIT_IDLE = 3'd2,
    S_APPLY     = 3'd3,
    S_ERR       = 3'd4
  } tuner_state_t;

  // Out-of-range codes return 9600 so the divider never sees a zero
  // denominator; such codes are rejected before the divider is started.
  function automatic int baud_hz(input logic [3:0] code);
    int hz;
    case (code)
      4'd0:    hz = 300;
      4'd1:    hz = 600;
      4'd2:    hz = 1200;
      4'd3:    hz = 2400;
      4'd4:    hz = 4800;
      4'd5:    hz = 9600;
      4'd6:    hz = 19200;
      4'd7:    hz = 38400;
      4'd8:    hz = 57600;
      4'd9:    hz = 115200;
      4'd10:   hz = 230400;
      4'd11:   hz = 460800;
      4'd12:   hz = 921600;
      default: hz = 9600;
    endcase
    return hz;
  endfunction

  function automatic stop_bit_length map_sbl(input logic [1:0] code);
    return (code == 2'b11) ? STOP_ONE : stop_bit_length'(code);
  endfunction

  function automatic tuner_output_bus_t default_cfg(input longint clk_freq);
    tuner_output_bus_t c;
    c.pulse_width = TUNER_PW_W'((clk_freq + 64'd4800) / 64'd9600);
    c.sbl         = STOP_ONE;
    c.data_len    = DATA_8;
    c.parity_on   = 1'b0;
    c.seniority_h = 1'b0;
    c.parity_set  = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// uart_baud_div
//   Restoring unsigned divider, one quotient bit per clock, NUM_W bits total.
//   The first quotient bit is produced on the start edge itself, so the
//   quotient and overflow flag are valid in the cycle done first reads high,
//   NUM_W cycles after the start cycle. Result is held until the next start.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load num/den and begin a division (single-cycle strobe)
//   num, den    : dividend / divisor, sampled only while start is high
//   done        : result valid (level, cleared by the next start)
//   quotient    : low PW_W bits of the quotient
//   overflow    : quotient is zero or does not fit in PW_W bits
module uart_baud_div #(
  parameter int NUM_W = 26,
  parameter int DEN_W = 20,
  parameter int PW_W  = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [PW_W-1:0]  quotient,
  output logic             overflow
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_reg, rem_next;
  logic [NUM_W-1:0] q_reg, q_next;
  logic [DEN_W-1:0] den_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             running_reg;
  logic             done_reg;

  // Dividend bits shift out of the top of q_reg while quotient bits shift in
  // at the bottom; after NUM_W steps q_reg holds the full quotient.
  logic [DEN_W-1:0] src_rem;
  logic [NUM_W-1:0] src_q;
  logic [DEN_W-1:0] src_den;
  logic [DEN_W:0]   rem_sh;
  logic             q_bit;

  always_comb begin
    src_rem = start ? '0 : rem_reg;
    src_q   = start ? num : q_reg;
    src_den = start ? den : den_reg;
    rem_sh  = {src_rem, src_q[NUM_W-1]};
    q_bit   = 1'b0;
    rem_next = rem_sh[DEN_W-1:0];
    if (rem_sh >= {1'b0, src_den}) begin
      q_bit = 1'b1;
      // Result is below src_den, so the dropped top bit is always zero.
      rem_next = rem_sh[DEN_W-1:0] - src_den;
    end
    q_next = {src_q[NUM_W-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg     <= '0;
      q_reg       <= '0;
      den_reg     <= '0;
      cnt_reg     <= '0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else if (start) begin
      den_reg     <= den;
      rem_reg     <= rem_next;
      q_reg       <= q_next;
      cnt_reg     <= CNT_W'(NUM_W - 1);
      running_reg <= 1'b1;
      done_reg    <= 1'b0;
    end else if (running_reg) begin
      rem_reg <= rem_next;
      q_reg   <= q_next;
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) begin
        running_reg <= 1'b0;
        done_reg    <= 1'b1;
      end
    end
  end

  assign done = done_reg;

  if (NUM_W > PW_W) begin : g_wide
    assign quotient = q_reg[PW_W-1:0];
    assign overflow = (q_reg == '0) || (|q_reg[NUM_W-1:PW_W]);
  end else begin : g_narrow
    assign quotient = PW_W'(q_reg);
    assign overflow = (q_reg == '0);
  end

endmodule

// File: rtl/uart_cfg_tuner.sv
// uart_cfg_tuner
//   Configuration store for the UART cores. Accepts a request over a
//   valid/ready handshake, converts the baud code to a rounded pulse width
//   with an iterative divider (or takes custom_div directly), and commits
//   the whole configuration atomically once the link is idle.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   cfg_valid/ready    : request handshake (ready only in IDLE)
//   br, custom_en,
//   custom_div, sbl,
//   data_len, parity_on,
//   seniority_h,
//   parity_set         : requested configuration fields
//   link_idle          : TX and RX both idle; gates the commit
//   cfg_o              : committed configuration (registered)
//   cfg_applied        : one-cycle pulse when cfg_o takes a new value
//   cfg_err            : one-cycle pulse when a request is rejected
//   busy               : FSM is not in IDLE
module uart_cfg_tuner
  import uart_tuner_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PW_W     = TUNER_PW_W,
  parameter int NUM_W    = $clog2(CLK_FREQ + 460_800 + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        br,
  input  logic              custom_en,
  input  logic [PW_W-1:0]   custom_div,
  input  logic [1:0]        sbl,
  input  logic [1:0]        data_len,
  input  logic              parity_on,
  input  logic              seniority_h,
  input  logic              parity_set,
  input  logic              link_idle,
  output tuner_output_bus_t cfg_o,
  output logic              cfg_applied,
  output logic              cfg_err,
  output logic              busy
);

  localparam tuner_output_bus_t RESET_CFG = default_cfg(CLK_FREQ);

  tuner_state_t      state_reg, state_next;
  tuner_output_bus_t shadow_reg;

  logic              div_start;
  logic [NUM_W-1:0]  div_num;
  logic [BAUD_W-1:0] div_den;
  logic              div_done;
  logic [PW_W-1:0]   div_q;
  logic              div_ovf;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cfg_valid) begin
          // Custom mode takes precedence over the baud code.
          if (custom_en)
            state_next = (custom_div != '0) ? S_WAIT_IDLE : S_ERR;
          else if (br > BR_MAX)
            state_next = S_ERR;
          else
            state_next = S_CALC;
        end
      end
      S_CALC:      if (div_done) state_next = div_ovf ? S_ERR : S_WAIT_IDLE;
      S_WAIT_IDLE: if (link_idle) state_next = S_APPLY;
      S_APPLY:     state_next = S_IDLE;
      S_ERR:       state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Adding baud/2 to the dividend turns the floor division into
  // round-to-nearest.
  always_comb begin
    div_start = (state_reg == S_IDLE) && cfg_valid && !custom_en && (br <= BR_MAX);
    div_num   = NUM_W'(CLK_FREQ + baud_hz(br) / 2);
    div_den   = BAUD_W'(baud_hz(br));
  end

  uart_baud_div #(
    .NUM_W(NUM_W),
    .DEN_W(BAUD_W),
    .PW_W (PW_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .num     (div_num),
    .den     (div_den),
    .done    (div_done),
    .quotient(div_q),
    .overflow(div_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      shadow_reg  <= RESET_CFG;
      cfg_o       <= RESET_CFG;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cfg_ready   <= (state_next == S_IDLE);
      busy        <= (state_next != S_IDLE);
      cfg_applied <= (state_reg == S_APPLY);
      cfg_err     <= (state_reg == S_ERR);

      if (state_reg == S_IDLE && cfg_valid) begin
        // pulse_width is overwritten by the divider result on the baud path.
        shadow_reg.pulse_width <= custom_div;
        shadow_reg.sbl         <= map_sbl(sbl);
        shadow_reg.data_len    <= data_length'(data_len);
        shadow_reg.parity_on   <= parity_on;
        shadow_reg.seniority_h <= seniority_h;
        shadow_reg.parity_set  <= parity_set;
      end

      if (state_reg == S_CALC && div_done && !div_ovf)
        shadow_reg.pulse_width <= div_q;

      if (state_reg == S_APPLY)
        cfg_o <= shadow_reg;
    end
  end

endmodule

// File: tb/tb_uart_cfg_tuner.sv
module tb_uart_cfg_tuner;
  import uart_tuner_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        valid_a, valid_b;
  logic [3:0]  br;
  logic        custom_en;
  logic [18:0] custom_div;
  logic [1:0]  sbl, data_len;
  logic        parity_on, seniority_h, parity_set, link_idle;

  logic ready_a, applied_a, err_a, busy_a;
  logic ready_b, applied_b, err_b, busy_b;
  tuner_output_bus_t cfg_o_a, cfg_o_b;

  uart_cfg_tuner #(.CLK_FREQ(50_000_000)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_valid(valid_a), .cfg_ready(ready_a),
    .br(br), .custom_en(custom_en), .custom_div(custom_div), .sbl(sbl),
    .data_len(data_len), .parity_on(parity_on), .seniority_h(seniority_h),
    .parity_set(parity_set), .link_idle(link_idle), .cfg_o(cfg_o_a),
    .cfg_applied(applied_a), .cfg_err(err_a), .busy(busy_a)
  );

  uart_cfg_tuner #(.CLK_FREQ(200_000_000)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(valid_b), .cfg_ready(ready_b),
    .br(br), .custom_en(custom_en), .custom_div(custom_div), .sbl(sbl),
    .data_len(data_len), .parity_on(parity_on), .seniority_h(seniority_h),
    .parity_set(parity_set), .link_idle(link_idle), .cfg_o(cfg_o_b),
    .cfg_applied(applied_b), .cfg_err(err_b), .busy(busy_b)
  );

  // NUM_W = 26 at 50 MHz, 28 at 200 MHz.
  localparam int LAT_DIV_A = 29;
  localparam int LAT_OVF_B = 30;

  typedef struct {
    bit                is_err;
    int                at;
    tuner_output_bus_t cfg;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  tuner_output_bus_t cur_a;

  function automatic tuner_output_bus_t mk_cfg(input int pw, input stop_bit_length s,
                                               input data_length d, input bit p,
                                               input bit sh, input bit ps);
    tuner_output_bus_t c;
    c.pulse_width = TUNER_PW_W'(pw);
    c.sbl = s;
    c.data_len = d;
    c.parity_on = p;
    c.seniority_h = sh;
    c.parity_set = ps;
    return c;
  endfunction

  // Drives one request in the current (negedge) cycle and records the
  // outcome expected lat cycles later. Returns at the negedge after accept.
  task automatic send_req(input bit which, input logic [3:0] br_v, input bit cust,
                          input logic [18:0] div_v, input logic [1:0] sbl_v,
                          input logic [1:0] dl_v, input bit p_on, input bit sen,
                          input bit pset, input bit is_err, input int lat,
                          input tuner_output_bus_t exp_cfg);
    int waited;
    exp_t item;
    waited = 0;
    while (!(which ? ready_b : ready_a) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if ((which ? ready_b : ready_a) !== 1'b1) begin
      errors++;
      $display("FAIL req_ready got 0 want 1 after %0d cycles", waited);
    end
    br = br_v; custom_en = cust; custom_div = div_v; sbl = sbl_v; data_len = dl_v;
    parity_on = p_on; seniority_h = sen; parity_set = pset;
    if (which) valid_b = 1'b1; else valid_a = 1'b1;
    item.is_err = is_err;
    item.at = cyc + lat;
    item.cfg = exp_cfg;
    sb_q.push_back(item);
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    // Data outside the accept cycle must be ignored.
    br = 4'($urandom); custom_en = 1'($urandom); custom_div = 19'($urandom);
    sbl = 2'($urandom); data_len = 2'($urandom);
    parity_on = 1'($urandom); seniority_h = 1'($urandom); parity_set = 1'($urandom);
  endtask

  // kind: 0 none within budget, 1 applied, 2 err, 3 both.
  task automatic wait_event(input bit which, input int budget, output int kind,
                            output int at, output tuner_output_bus_t seen);
    bit found;
    kind = 0; at = -1; seen = '0; found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (which ? (applied_b || err_b) : (applied_a || err_a)) begin
        kind = (which ? {30'd0, err_b, applied_b} : {30'd0, err_a, applied_a});
        at = cyc;
        seen = which ? cfg_o_b : cfg_o_a;
        found = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    tuner_output_bus_t e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = mk_cfg(5208, STOP_ONE, DATA_8, 0, 0, 0);
    checks += 6;
    if (cfg_o_a !== e) begin errors++; $display("FAIL reset_cfg got %h want %h", cfg_o_a, e); end
    if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_a); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    if (applied_a !== 1'b0 || err_a !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got %b%b want 00", applied_a, err_a);
    end
    e = mk_cfg(20833, STOP_ONE, DATA_8, 0, 0, 0);
    if (cfg_o_b !== e) begin errors++; $display("FAIL reset_cfg_b got %h want %h", cfg_o_b, e); end
    if (ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b got %b want 1", ready_b); end
    cur_a = mk_cfg(5208, STOP_ONE, DATA_8, 0, 0, 0);
    $display("reset: cfg_a=%h cfg_b=%h", cfg_o_a, cfg_o_b);
  endtask

  task automatic test_divider();
    int kind, at;
    tuner_output_bus_t seen, e;
    exp_t ex;
    link_idle = 1'b1;
    e = mk_cfg(434, STOP_TWO, DATA_6, 1, 0, 1);
    send_req(0, 4'd9, 0, 19'd0, 2'b10, 2'b01, 1, 0, 1, 0, LAT_DIV_A, e);
    wait_event(0, 60, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 4;
    if (kind !== 1) begin errors++; $display("FAIL div115k_kind got %0d want 1", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL div115k_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL div115k_cfg got %h want %h", seen, ex.cfg); end
    if (ready_a !== 1'b1) begin errors++; $display("FAIL div115k_ready got %b want 1", ready_a); end
    $display("txn br=115200 kind=%0d cyc=%0d pw=%0d", kind, at, seen.pulse_width);
    cur_a = e;

    // Reserved stop code 2'b11 maps to ONE.
    e = mk_cfg(166667, STOP_ONE, DATA_8, 0, 1, 0);
    send_req(0, 4'd0, 0, 19'd0, 2'b11, 2'b11, 0, 1, 0, 0, LAT_DIV_A, e);
    wait_event(0, 60, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 3;
    if (kind !== 1) begin errors++; $display("FAIL div300_kind got %0d want 1", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL div300_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL div300_cfg got %h want %h", seen, ex.cfg); end
    $display("txn br=300 kind=%0d cyc=%0d pw=%0d", kind, at, seen.pulse_width);
    cur_a = e;
  endtask

  task automatic test_custom_wait();
    int kind, at;
    tuner_output_bus_t seen, e;
    exp_t ex;
    link_idle = 1'b0;
    // br out of range is irrelevant when custom_en is set.
    e = mk_cfg(100, STOP_ONE_HALF, DATA_7, 1, 1, 0);
    send_req(0, 4'd15, 1, 19'd100, 2'b01, 2'b10, 1, 1, 0, 0, 13, e);
    for (int k = 1; k <= 10; k++) begin
      checks += 3;
      if (cfg_o_a !== cur_a) begin errors++; $display("FAIL hold_cfg k=%0d got %h want %h", k, cfg_o_a, cur_a); end
      if (ready_a !== 1'b0) begin errors++; $display("FAIL hold_ready k=%0d got %b want 0", k, ready_a); end
      if (busy_a !== 1'b1) begin errors++; $display("FAIL hold_busy k=%0d got %b want 1", k, busy_a); end
      if (k < 10) @(negedge clk);
    end
    @(negedge clk);
    link_idle = 1'b1;
    wait_event(0, 20, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 3;
    if (kind !== 1) begin errors++; $display("FAIL custom_kind got %0d want 1", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL custom_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL custom_cfg got %h want %h", seen, ex.cfg); end
    $display("txn custom=100 kind=%0d cyc=%0d pw=%0d", kind, at, seen.pulse_width);
    cur_a = e;
  endtask

  task automatic test_errors();
    int kind, at;
    tuner_output_bus_t seen;
    exp_t ex;
    link_idle = 1'b1;
    send_req(0, 4'b1101, 0, 19'd0, 2'b00, 2'b11, 0, 0, 0, 1, 2, cur_a);
    wait_event(0, 20, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 3;
    if (kind !== 2) begin errors++; $display("FAIL br_err_kind got %0d want 2", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL br_err_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL br_err_cfg got %h want %h", seen, ex.cfg); end
    $display("txn br=13 kind=%0d cyc=%0d", kind, at);

    send_req(0, 4'd9, 1, 19'd0, 2'b10, 2'b00, 1, 1, 1, 1, 2, cur_a);
    wait_event(0, 20, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 3;
    if (kind !== 2) begin errors++; $display("FAIL div0_err_kind got %0d want 2", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL div0_err_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL div0_err_cfg got %h want %h", seen, ex.cfg); end
    $display("txn custom=0 kind=%0d cyc=%0d", kind, at);
  endtask

  task automatic test_overflow();
    int kind, at;
    tuner_output_bus_t seen, e;
    exp_t ex;
    link_idle = 1'b1;
    e = mk_cfg(777, STOP_TWO, DATA_5, 0, 0, 1);
    send_req(1, 4'd0, 1, 19'd777, 2'b10, 2'b00, 0, 0, 1, 0, 3, e);
    wait_event(1, 20, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 3;
    if (kind !== 1) begin errors++; $display("FAIL b_custom_kind got %0d want 1", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL b_custom_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL b_custom_cfg got %h want %h", seen, ex.cfg); end
    $display("txn b custom=777 kind=%0d cyc=%0d", kind, at);

    // 200 MHz / 300 baud = 666667, above the 19-bit range.
    send_req(1, 4'd0, 0, 19'd0, 2'b00, 2'b11, 1, 1, 1, 1, LAT_OVF_B, e);
    wait_event(1, 60, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 3;
    if (kind !== 2) begin errors++; $display("FAIL ovf_kind got %0d want 2", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL ovf_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL ovf_cfg got %h want %h", seen, ex.cfg); end
    $display("txn b br=300 kind=%0d cyc=%0d", kind, at);
  endtask

  task automatic test_reset_midcalc();
    int kind, at;
    bit pulse_seen;
    tuner_output_bus_t seen, e, d;
    exp_t ex;
    link_idle = 1'b1;
    send_req(0, 4'd5, 0, 19'd0, 2'b10, 2'b00, 1, 0, 0, 0, LAT_DIV_A, cur_a);
    ex = sb_q.pop_back();  // request is discarded by the reset below
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    d = mk_cfg(5208, STOP_ONE, DATA_8, 0, 0, 0);
    checks += 3;
    if (cfg_o_a !== d) begin errors++; $display("FAIL midrst_cfg got %h want %h", cfg_o_a, d); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_a); end
    if (ready_a !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready_a); end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (applied_a || err_a) pulse_seen = 1;
      @(negedge clk);
    end
    checks++;
    if (pulse_seen) begin errors++; $display("FAIL midrst_pulse got 1 want 0"); end
    cur_a = d;

    e = mk_cfg(5208, STOP_ONE, DATA_5, 1, 0, 0);
    send_req(0, 4'd5, 0, 19'd0, 2'b00, 2'b00, 1, 0, 0, 0, LAT_DIV_A, e);
    wait_event(0, 60, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 3;
    if (kind !== 1) begin errors++; $display("FAIL fresh_kind got %0d want 1", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL fresh_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL fresh_cfg got %h want %h", seen, ex.cfg); end
    $display("txn br=9600 after reset kind=%0d cyc=%0d", kind, at);
    cur_a = e;
  endtask

  task automatic test_back_to_back();
    int kind, at;
    tuner_output_bus_t seen, e1, e2;
    exp_t ex;
    link_idle = 1'b1;
    e1 = mk_cfg(55, STOP_ONE, DATA_8, 0, 1, 1);
    send_req(0, 4'd3, 1, 19'd55, 2'b00, 2'b11, 0, 1, 1, 0, 3, e1);
    wait_event(0, 20, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 4;
    if (kind !== 1) begin errors++; $display("FAIL b2b1_kind got %0d want 1", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL b2b1_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL b2b1_cfg got %h want %h", seen, ex.cfg); end
    if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b1_ready got %b want 1", ready_a); end
    $display("txn custom=55 kind=%0d cyc=%0d", kind, at);

    // Second request issued in the same cycle as the applied pulse.
    e2 = mk_cfg(434, STOP_TWO, DATA_8, 0, 0, 1);
    send_req(0, 4'd9, 0, 19'd0, 2'b10, 2'b11, 0, 0, 1, 0, LAT_DIV_A, e2);
    checks++;
    if (applied_a !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width got %b want 0", applied_a); end
    wait_event(0, 60, kind, at, seen);
    ex = sb_q.pop_front();
    checks += 3;
    if (kind !== 1) begin errors++; $display("FAIL b2b2_kind got %0d want 1", kind); end
    if (at !== ex.at) begin errors++; $display("FAIL b2b2_cycle got %0d want %0d", at, ex.at); end
    if (seen !== ex.cfg) begin errors++; $display("FAIL b2b2_cfg got %h want %h", seen, ex.cfg); end
    $display("txn b2b br=115200 kind=%0d cyc=%0d pw=%0d", kind, at, seen.pulse_width);
    cur_a = e2;
  endtask

  initial begin
    rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    br = '0; custom_en = 1'b0; custom_div = '0; sbl = '0; data_len = '0;
    parity_on = 1'b0; seniority_h = 1'b0; parity_set = 1'b0; link_idle = 1'b1;
    @(negedge clk);
    test_reset();
    test_divider();
    test_custom_wait();
    test_errors();
    test_overflow();
    test_reset_midcalc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
